// File: rtl/aes_block_packer.sv
// Packs four 32-bit plaintext words into one 128-bit AES block and counts blocks per job.
// Optional AES_PACK_BYTE_SWAP_EN byte-reverses each word before storage (FIPS-197 byte order).
module aes_block_packer #(
  parameter int WORD_W          = 32,
  parameter int WORDS_PER_BLOCK = 4,
  parameter int CNT_W           = 16
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              clear_i,
  input  logic                              start_i,
  input  logic [CNT_W-1:0]                  nblocks_i,
  input  logic [WORD_W-1:0]                 word_data_i,
  input  logic                              word_valid_i,
  output logic                              word_ready_o,
  output logic [WORD_W*WORDS_PER_BLOCK-1:0] blk_data_o,
  output logic                              blk_valid_o,
  input  logic                              blk_ready_i,
  output logic                              busy_o,
  output logic                              done_o,
  output logic [CNT_W-1:0]                  blk_cnt_o
);

  localparam int BLK_W = WORD_W * WORDS_PER_BLOCK;
  localparam int IDX_W = $clog2(WORDS_PER_BLOCK);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   nblk_q, nblk_d;
  logic [BLK_W-1:0]   data_q, data_d;
  logic [WORD_W-1:0]  word_in;

`ifdef AES_PACK_BYTE_SWAP_EN
  always_comb begin
    word_in = '0;
    for (int b = 0; b < WORD_W / 8; b++) begin
      word_in[8*b +: 8] = word_data_i[WORD_W-8-8*b +: 8];
    end
  end
`else
  assign word_in = word_data_i;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    nblk_d  = nblk_q;
    data_d  = data_q;
    if (clear_i) begin
      state_d = IDLE;
      idx_d   = '0;
      cnt_d   = '0;
      data_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            cnt_d = '0;
            idx_d = '0;
            if (nblocks_i != '0) begin
              nblk_d  = nblocks_i;
              state_d = FILL;
            end else begin
              state_d = DONE;
            end
          end
        end
        FILL: begin
          if (word_valid_i) begin
            data_d[idx_q*WORD_W +: WORD_W] = word_in;
            idx_d = idx_q + IDX_W'(1);
            if (idx_q == IDX_W'(WORDS_PER_BLOCK - 1)) begin
              idx_d   = '0;
              state_d = HOLD;
            end
          end
        end
        HOLD: begin
          // Single block buffer: no word is taken until this block leaves.
          if (blk_ready_i) begin
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = (cnt_d == nblk_q) ? DONE : FILL;
          end
        end
        DONE: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      nblk_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      nblk_q  <= nblk_d;
      data_q  <= data_d;
    end
  end

  // Handshake outputs come only from registered state, never from valid/ready inputs.
  assign word_ready_o = (state_q == FILL);
  assign blk_valid_o  = (state_q == HOLD);
  assign busy_o       = (state_q == FILL) || (state_q == HOLD);
  assign done_o       = (state_q == DONE);
  assign blk_data_o   = data_q;
  assign blk_cnt_o    = cnt_q;

endmodule
